// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, mid-bit sampling at a fixed integer
// bit period, byte delivery on a valid/ready stream with framing and overrun pulses.
module uart_rx #(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE       = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state;
  logic             sync1;
  logic             rxd_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  // Receive FSM with registered stream outputs and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rxd_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxd_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              // A held byte is replaced only if it is being consumed this cycle.
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; expected events come from
// frame start times plus the fixed receive latency, and from a byte-level model.
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = 8;
  // rxd change -> rx_valid/frame_err visible: 2 sync + HALF + 9 bit periods + 1
  localparam int LAT = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         hs_cyc[$];
  logic [7:0] hs_data[$];
  int         fe_cyc[$];
  int         ov_cyc[$];
  logic       busy_hist[int];

  uart_rx #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle: handshakes, error pulses, busy history.
  always @(negedge clk) begin
    busy_hist[cyc] = busy;
    if (rx_valid && rx_ready) begin
      hs_cyc.push_back(cyc);
      hs_data.push_back(rx_data);
    end
    if (frame_err) fe_cyc.push_back(cyc);
    if (overrun) ov_cyc.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_cyc.delete(); hs_data.delete(); fe_cyc.delete(); ov_cyc.delete();
  endtask

  // Drives the first nslots bit slots of a frame (start, 8 data LSB first, stop).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nslots,
                            output int r);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    r = cyc;
    for (int i = 0; i < nslots; i++) begin
      rxd = bits[i];
      step(CPB);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_single();
    int r;
    clear_logs();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 10, r);
    step(20);
    n_checks++; if (hs_cyc.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", hs_cyc.size()); end
    if (hs_cyc.size() >= 1) begin
      n_checks++; if (hs_data[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", hs_data[0]); end
      n_checks++; if (hs_cyc[0] !== r + LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", hs_cyc[0] - r, LAT); end
    end
    n_checks++; if (fe_cyc.size() !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected 0", fe_cyc.size()); end
    n_checks++; if (ov_cyc.size() !== 0) begin n_fail++; $display("FAIL single_overrun: got %0d expected 0", ov_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[6];
    int         starts[6];
    clear_logs();
    rx_ready = 1'b1;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) send_frame(bytes[i], 1'b1, 10, starts[i]);
    step(20);
    n_checks++; if (hs_cyc.size() !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d expected 6", hs_cyc.size()); end
    for (int i = 0; i < 6; i++) begin
      if (hs_cyc.size() > i) begin
        n_checks++; if (hs_data[i] !== bytes[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, hs_data[i], bytes[i]); end
        n_checks++; if (hs_cyc[i] !== starts[i] + LAT) begin n_fail++; $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, hs_cyc[i], starts[i] + LAT); end
      end
    end
    n_checks++; if (fe_cyc.size() + ov_cyc.size() !== 0) begin n_fail++; $display("FAIL b2b_errors: got %0d expected 0", fe_cyc.size() + ov_cyc.size()); end
  endtask

  task automatic test_glitch();
    int r;
    clear_logs();
    r = cyc;
    rxd = 1'b0;
    step(5);
    rxd = 1'b1;
    step(30);
    n_checks++; if (busy_hist[r + 6] !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_mid: got %b expected 1", busy_hist[r + 6]); end
    n_checks++; if (busy_hist[r + 12] !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b expected 0", busy_hist[r + 12]); end
    n_checks++; if (hs_cyc.size() !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", hs_cyc.size()); end
    n_checks++; if (fe_cyc.size() + ov_cyc.size() !== 0) begin n_fail++; $display("FAIL glitch_errors: got %0d expected 0", fe_cyc.size() + ov_cyc.size()); end
  endtask

  task automatic test_framing();
    int r;
    int h;
    clear_logs();
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0, 10, r);
    step(40);
    h = cyc;
    rxd = 1'b1;
    step(20);
    n_checks++; if (fe_cyc.size() !== 1) begin n_fail++; $display("FAIL frame_err_count: got %0d expected 1", fe_cyc.size()); end
    if (fe_cyc.size() >= 1) begin
      n_checks++; if (fe_cyc[0] !== r + LAT) begin n_fail++; $display("FAIL frame_err_time: got %0d expected %0d", fe_cyc[0] - r, LAT); end
    end
    n_checks++; if (hs_cyc.size() !== 0) begin n_fail++; $display("FAIL frame_err_valid: got %0d expected 0", hs_cyc.size()); end
    n_checks++; if (busy_hist[h + 2] !== 1'b1) begin n_fail++; $display("FAIL frame_busy_hold: got %b expected 1", busy_hist[h + 2]); end
    n_checks++; if (busy_hist[h + 3] !== 1'b0) begin n_fail++; $display("FAIL frame_busy_release: got %b expected 0", busy_hist[h + 3]); end
  endtask

  task automatic test_overrun();
    int r1;
    int r2;
    int c;
    clear_logs();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 10, r1);
    send_frame(8'h22, 1'b1, 10, r2);
    step(20);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data_held: got %h expected 11", rx_data); end
    n_checks++; if (ov_cyc.size() !== 1) begin n_fail++; $display("FAIL ovr_count: got %0d expected 1", ov_cyc.size()); end
    if (ov_cyc.size() >= 1) begin
      n_checks++; if (ov_cyc[0] !== r2 + LAT) begin n_fail++; $display("FAIL ovr_time: got %0d expected %0d", ov_cyc[0] - r2, LAT); end
    end
    c = cyc;
    rx_ready = 1'b1;
    step(1);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume_clear: got %b expected 0", rx_valid); end
    n_checks++; if (hs_cyc.size() !== 1) begin n_fail++; $display("FAIL ovr_handshakes: got %0d expected 1", hs_cyc.size()); end
    if (hs_cyc.size() >= 1) begin
      n_checks++; if (hs_data[0] !== 8'h11 || hs_cyc[0] !== c) begin n_fail++; $display("FAIL ovr_consumed: got %h@%0d expected 11@%0d", hs_data[0], hs_cyc[0], c); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int r;
    clear_logs();
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 10, r);
    step(5);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending: got %b expected 1", rx_valid); end
    send_frame(8'h77, 1'b1, 5, r);
    rxd = 1'b1;
    step(8);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
    rx_ready = 1'b1;
    step(30);
    send_frame(8'h81, 1'b1, 10, r);
    step(20);
    n_checks++; if (hs_cyc.size() !== 1) begin n_fail++; $display("FAIL rstmid_after_count: got %0d expected 1", hs_cyc.size()); end
    if (hs_cyc.size() >= 1) begin
      n_checks++; if (hs_data[0] !== 8'h81 || hs_cyc[0] !== r + LAT) begin n_fail++; $display("FAIL rstmid_after_byte: got %h@%0d expected 81@%0d", hs_data[0], hs_cyc[0], r + LAT); end
    end
    n_checks++; if (fe_cyc.size() !== 0) begin n_fail++; $display("FAIL rstmid_frame_err: got %0d expected 0", fe_cyc.size()); end
  endtask

  // Random bytes, gaps and stop-bit corruption; good frames deliver, bad ones flag.
  task automatic test_random();
    logic [7:0] exp_data[$];
    int         exp_cyc[$];
    int         exp_fe[$];
    logic [7:0] b;
    logic       stop;
    int         gap;
    int         r;
    clear_logs();
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(0, 20));
      if (gap > 0) step(gap);
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, 10, r);
      if (stop) begin
        exp_data.push_back(b);
        exp_cyc.push_back(r + LAT);
      end else begin
        exp_fe.push_back(r + LAT);
        rxd = 1'b1;
        step(CPB);
      end
    end
    step(20);
    n_checks++; if (hs_cyc.size() !== exp_cyc.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", hs_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size(); i++) begin
      if (hs_cyc.size() > i) begin
        n_checks++; if (hs_data[i] !== exp_data[i] || hs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %h@%0d expected %h@%0d", i, hs_data[i], hs_cyc[i], exp_data[i], exp_cyc[i]); end
      end
    end
    n_checks++; if (fe_cyc.size() !== exp_fe.size()) begin n_fail++; $display("FAIL rand_fe_count: got %0d expected %0d", fe_cyc.size(), exp_fe.size()); end
    for (int i = 0; i < exp_fe.size(); i++) begin
      if (fe_cyc.size() > i) begin
        n_checks++; if (fe_cyc[i] !== exp_fe[i]) begin n_fail++; $display("FAIL rand_fe_time[%0d]: got %0d expected %0d", i, fe_cyc[i], exp_fe[i]); end
      end
    end
    n_checks++; if (ov_cyc.size() !== 0) begin n_fail++; $display("FAIL rand_overrun: got %0d expected 0", ov_cyc.size()); end
  endtask

  initial begin
    step(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
